// File: rtl/bcd_count_ctrl.sv
// Two-digit BCD up/down counter with start/stop/clear/load commands and an
// internal prescaler that paces count steps for the seven-segment decoders.
module bcd_count_ctrl #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned PW       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       up_down,
    output logic [7:0] bcd_out,
    output logic       running,
    output logic       tick,
    output logic       wrap,
    output logic       load_error
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    bcd_q, bcd_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;
    logic          lerr_q, lerr_d;

    logic          load_ok;
    logic          step_due;
    logic          step_en;
    logic [7:0]    bcd_step;
    logic          step_wrap;

    assign load_ok = (load_value[7:4] <= 4'd9) && (load_value[3:0] <= 4'd9);

    // Any clear, load (accepted or not) or stop on the due edge swallows the step.
    assign step_due = (state_q == StRun) && (presc_q == PrescLast);
    assign step_en  = step_due && !stop && !clear && !load;

    always_comb begin
        bcd_step  = bcd_q;
        step_wrap = 1'b0;
        if (up_down) begin
            if (bcd_q[3:0] == 4'd9) begin
                bcd_step[3:0] = 4'd0;
                if (bcd_q[7:4] == 4'd9) begin
                    bcd_step[7:4] = 4'd0;
                    step_wrap     = 1'b1;
                end else begin
                    bcd_step[7:4] = bcd_q[7:4] + 4'd1;
                end
            end else begin
                bcd_step[3:0] = bcd_q[3:0] + 4'd1;
            end
        end else begin
            if (bcd_q[3:0] == 4'd0) begin
                bcd_step[3:0] = 4'd9;
                if (bcd_q[7:4] == 4'd0) begin
                    bcd_step[7:4] = 4'd9;
                    step_wrap     = 1'b1;
                end else begin
                    bcd_step[7:4] = bcd_q[7:4] - 4'd1;
                end
            end else begin
                bcd_step[3:0] = bcd_q[3:0] - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        bcd_d   = bcd_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        lerr_d  = 1'b0;

        if (stop) begin
            state_d = StIdle;
        end else if (start && state_q == StIdle) begin
            state_d = StRun;
        end

        if (state_q == StRun && !stop) begin
            presc_d = step_due ? '0 : presc_q + 1'b1;
        end else begin
            presc_d = '0;
        end

        if (clear) begin
            bcd_d   = 8'h00;
            presc_d = '0;
        end else if (load) begin
            if (load_ok) begin
                bcd_d   = load_value;
                presc_d = '0;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (step_en) begin
            bcd_d  = bcd_step;
            tick_d = 1'b1;
            wrap_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            bcd_q   <= 8'h00;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            bcd_q   <= bcd_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            lerr_q  <= lerr_d;
        end
    end

    assign bcd_out    = bcd_q;
    assign running    = (state_q == StRun);
    assign tick       = tick_q;
    assign wrap       = wrap_q;
    assign load_error = lerr_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed-vector bench for bcd_count_ctrl with TICK_DIV=4; expected values
// are hand-computed from the step timing (first step four edges after start).
module tb_bcd_count_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, stop, clear, load, up_down;
    logic [7:0] load_value;
    logic [7:0] bcd_out;
    logic       running, tick, wrap, load_error;

    int n_vec = 0;
    int n_err = 0;

    bcd_count_ctrl #(.TICK_DIV(4), .PW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .bcd_out    (bcd_out),
        .running    (running),
        .tick       (tick),
        .wrap       (wrap),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] b, input logic r,
                           input logic t, input logic w, input logic le);
        check({tag, ".bcd"}, {24'd0, bcd_out}, {24'd0, b});
        check({tag, ".run"}, {31'd0, running}, {31'd0, r});
        check({tag, ".tick"}, {31'd0, tick}, {31'd0, t});
        check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, w});
        check({tag, ".lerr"}, {31'd0, load_error}, {31'd0, le});
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v;
        cyc();
        load = 1'b0;
    endtask

    task automatic do_start(input logic dir);
        up_down = dir; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        up_down = 1'b1; load_value = 8'h00;
        cyc(2);
        reset = 1'b0;
        chk_out("reset", 8'h00, 0, 0, 0, 0);

        // Basic up count: steps on edges 4 and 8 after the start edge.
        do_start(1'b1);
        chk_out("up.e0", 8'h00, 1, 0, 0, 0);
        cyc(3);
        chk_out("up.e3", 8'h00, 1, 0, 0, 0);
        cyc();
        chk_out("up.e4", 8'h01, 1, 1, 0, 0);
        cyc();
        chk_out("up.e5", 8'h01, 1, 0, 0, 0);
        cyc(3);
        chk_out("up.e8", 8'h02, 1, 1, 0, 0);
        do_stop();
        chk_out("up.stop", 8'h02, 0, 0, 0, 0);

        // Up wrap 98 -> 99 -> 00 -> 01.
        do_load(8'h98);
        chk_out("wrapu.load", 8'h98, 0, 0, 0, 0);
        do_start(1'b1);
        cyc(4);
        chk_out("wrapu.99", 8'h99, 1, 1, 0, 0);
        cyc(4);
        chk_out("wrapu.00", 8'h00, 1, 1, 1, 0);
        cyc();
        chk_out("wrapu.00b", 8'h00, 1, 0, 0, 0);
        cyc(3);
        chk_out("wrapu.01", 8'h01, 1, 1, 0, 0);
        do_stop();

        // Down wrap 00 -> 99 -> 98, then load 10 mid-run and borrow to 09.
        clear = 1'b1; cyc(); clear = 1'b0;
        chk_out("clr", 8'h00, 0, 0, 0, 0);
        do_start(1'b0);
        cyc(4);
        chk_out("wrapd.99", 8'h99, 1, 1, 1, 0);
        cyc(4);
        chk_out("wrapd.98", 8'h98, 1, 1, 0, 0);
        do_load(8'h10);
        chk_out("down.ld10", 8'h10, 1, 0, 0, 0);
        cyc(4);
        chk_out("down.09", 8'h09, 1, 1, 0, 0);
        do_stop();

        // Rejected loads leave the count alone.
        do_load(8'h3A);
        chk_out("lerr.3A", 8'h09, 0, 0, 0, 1);
        cyc();
        chk_out("lerr.3A.b", 8'h09, 0, 0, 0, 0);
        do_load(8'hA3);
        chk_out("lerr.A3", 8'h09, 0, 0, 0, 1);
        do_load(8'h42);
        chk_out("ld.42", 8'h42, 0, 0, 0, 0);

        // start+stop together: stop wins.
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk_out("ss", 8'h42, 0, 0, 0, 0);
        cyc(5);
        chk_out("ss.idle", 8'h42, 0, 0, 0, 0);

        // clear beats load.
        clear = 1'b1; load = 1'b1; load_value = 8'h55;
        cyc();
        clear = 1'b0; load = 1'b0;
        chk_out("clr+ld", 8'h00, 0, 0, 0, 0);

        // Load on the step edge suppresses the step and restarts the phase.
        do_start(1'b1);
        cyc(3);
        do_load(8'h20);
        chk_out("ldstep", 8'h20, 1, 0, 0, 0);
        cyc(3);
        chk_out("ldstep.e3", 8'h20, 1, 0, 0, 0);
        cyc();
        chk_out("ldstep.21", 8'h21, 1, 1, 0, 0);

        // Direction change mid-run keeps phase: next step counts down.
        cyc(2);
        up_down = 1'b0;
        cyc(2);
        chk_out("dirchg", 8'h20, 1, 1, 0, 0);

        // Stop on the step edge suppresses the step.
        cyc(3);
        do_stop();
        chk_out("stopstep", 8'h20, 0, 0, 0, 0);

        // Reset mid-run with prescaler at 2.
        do_start(1'b1);
        cyc(2);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk_out("rst.mid", 8'h00, 0, 0, 0, 0);
        cyc(6);
        chk_out("rst.idle", 8'h00, 0, 0, 0, 0);
        do_start(1'b1);
        cyc(3);
        chk_out("rst.e3", 8'h00, 1, 0, 0, 0);
        cyc();
        chk_out("rst.e4", 8'h01, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
